seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
- Consumes the 8-channel display mux outputs: Disp_num[31:0], point_out[7:0], LE_out[7:0].
- Drives an 8-digit, common-anode, time-multiplexed seven-segment display.
- Contains a scan prescaler, a digit counter, a per-frame input snapshot, a hex-to-segment decoder, per-digit decimal points and a per-digit blink (LE) engine.
- All display outputs are registered, active-low.

Parameters:
SCAN_DIV, 16'd50000, clk cycles per digit slot; legal 1..65535
BLINK_FRAMES, 8'd64, full frames per blink half-period; legal 1..255
DEAD_CYC, 4'd4, anode dead-time clocks at the start of each slot (used only with the optional feature); must be < SCAN_DIV

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
Disp_num  input  32  hex value; nibble i drives digit i, digit 0 rightmost
point_in  input  8  bit i=1 lights the decimal point of digit i
LE_in  input  8  bit i=1 makes digit i blink
AN  output  8  digit anodes, active-low, one-hot-low while scanning
SEGMENT  output  8  {dp,g,f,e,d,c,b,a}, active-low
frame_done  output  1  one-clock pulse when the digit-7 slot ends

Behaviour:
- Reset (async assert, sync release):
  - AN=8'hFF and SEGMENT=8'hFF.
  - Prescaler, dig, blink counter and blink phase are all 0; the snapshot is 0 and prime=1.
  - frame_done=0.
- Prescaler:
  - Counts 0..SCAN_DIV-1. tick=1 when cnt==SCAN_DIV-1, then cnt wraps to 0.
  - With SCAN_DIV=1, tick=1 every clock.
- Digit counter dig[2:0]: increments on tick and wraps 7->0.
- frame_done: equals tick && dig==7, registered, so the pulse aligns with the first clock of the new digit-0 slot.
- Snapshot {num,pt,le}:
  - Loads Disp_num/point_in/LE_in on tick && dig==7, and on every clock while prime=1.
  - prime clears on the first tick after reset.
  - Input changes mid-frame must not appear until the next frame.
- Output registers, loaded every clock from the current state (1-clock latency versus dig):
  - AN = ~(8'b1 << dig).
  - SEGMENT[6:0] = hex decode of num[4*dig+3 -: 4].
  - SEGMENT[7] = ~pt[dig].
- Hex decode table, 8-bit with dp off:
  - 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8
  - 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E
- Blink:
  - blink_cnt counts frame_done events 0..BLINK_FRAMES-1.
  - On the frame_done where blink_cnt==BLINK_FRAMES-1: phase toggles and blink_cnt returns to 0.
  - While phase=1 and le[dig]=1: SEGMENT=8'hFF, including dp. AN is still driven, so slot timing is unchanged.
- Reset mid-frame: outputs return to 8'hFF asynchronously, and scanning restarts at digit 0 after release.
- No combinational path from any input to any output.

Optional Feature:
- SEG7_DEADTIME_EN defined:
  - During the first DEAD_CYC clocks of every slot (cnt<DEAD_CYC), AN=8'hFF.
  - SEGMENT is still updated during that window, which suppresses ghosting on the next digit.
  - Slot length is unchanged.
- Undefined: no dead-time; AN is active for the whole slot. DEAD_CYC is ignored.

Test Plan:
- SCAN_DIV=4, rst high 3 clocks then low, Disp_num=32'h76543210, point_in=0, LE_in=0:
  - AN sequences FE,FD,FB,F7,EF,DF,BF,7F, each for 4 clocks.
  - SEGMENT sequences C0,F9,A4,B0,99,92,82,F8.
  - frame_done pulses once every 32 clocks.
- Disp_num=32'hFEDCBA98, point_in=8'h05:
  - Digits 0..7 show 80,90,88,83,C6,A1,86,8E.
  - The dp bit is cleared on digits 0 and 2 only, e.g. digit0=8'h00, digit2=8'h08.
- Change Disp_num from 32'h11111111 to 32'h22222222 while dig==3:
  - Digits 3..7 of the current frame still show F9.
  - The next frame shows A4 on every digit.
- BLINK_FRAMES=2, LE_in=8'h02, Disp_num=0:
  - Digit 1 shows C0 for 2 frames, then FF for 2 frames, repeating.
  - Other digits constant C0, and the AN sequence is never interrupted.
- Assert rst while dig==5, mid-slot:
  - AN and SEGMENT go to FF in the same timestep, without waiting for a clock.
  - After release, the first active AN is FE.
- With SEG7_DEADTIME_EN, SCAN_DIV=8, DEAD_CYC=2:
  - Each slot shows AN=FF for 2 clocks, then the one-hot-low value for 6 clocks.
  - The frame period stays at 64 clocks.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode seven-segment driver with per-frame snapshot and blink.
// Optional anode dead-time at the start of each slot when SEG7_DEADTIME_EN is defined.
module seg7_scan_driver #(
    parameter logic [15:0] SCAN_DIV     = 16'd50000,
    parameter logic [7:0]  BLINK_FRAMES = 8'd64,
    parameter logic [3:0]  DEAD_CYC     = 4'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Disp_num,
    input  logic [7:0]  point_in,
    input  logic [7:0]  LE_in,
    output logic [7:0]  AN,
    output logic [7:0]  SEGMENT,
    output logic        frame_done
);

`ifdef SEG7_DEADTIME_EN
    localparam bit DEAD_EN = 1'b1;
`else
    localparam bit DEAD_EN = 1'b0;
`endif

    logic [15:0] cnt;
    logic [2:0]  dig;
    logic        prime;
    logic [31:0] num;
    logic [7:0]  pt;
    logic [7:0]  le;
    logic [7:0]  blink_cnt;
    logic        phase;

    logic        tick_c;
    logic        frame_end_c;
    logic [3:0]  nib_c;
    logic [6:0]  hex_c;
    logic [7:0]  an_c;
    logic [7:0]  seg_c;

    assign tick_c      = (cnt == SCAN_DIV - 16'd1);
    assign frame_end_c = tick_c && (dig == 3'd7);

    // Slot prescaler and digit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 16'd0;
            dig <= 3'd0;
        end else if (tick_c) begin
            cnt <= 16'd0;
            dig <= dig + 3'd1;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // Input snapshot: tracks inputs until the first slot ends, then only at frame boundaries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prime <= 1'b1;
            num   <= 32'd0;
            pt    <= 8'd0;
            le    <= 8'd0;
        end else begin
            if (prime || frame_end_c) begin
                num <= Disp_num;
                pt  <= point_in;
                le  <= LE_in;
            end
            if (tick_c) begin
                prime <= 1'b0;
            end
        end
    end

    // Blink engine advances on the same frame boundary that raises frame_done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= 8'd0;
            phase     <= 1'b0;
        end else if (frame_end_c) begin
            if (blink_cnt == BLINK_FRAMES - 8'd1) begin
                blink_cnt <= 8'd0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 8'd1;
            end
        end
    end

    assign nib_c = num[{dig, 2'b00} +: 4];

    always_comb begin
        hex_c = 7'h7F;
        case (nib_c)
            4'h0: hex_c = 7'h40;
            4'h1: hex_c = 7'h79;
            4'h2: hex_c = 7'h24;
            4'h3: hex_c = 7'h30;
            4'h4: hex_c = 7'h19;
            4'h5: hex_c = 7'h12;
            4'h6: hex_c = 7'h02;
            4'h7: hex_c = 7'h78;
            4'h8: hex_c = 7'h00;
            4'h9: hex_c = 7'h10;
            4'hA: hex_c = 7'h08;
            4'hB: hex_c = 7'h03;
            4'hC: hex_c = 7'h46;
            4'hD: hex_c = 7'h21;
            4'hE: hex_c = 7'h06;
            4'hF: hex_c = 7'h0E;
            default: hex_c = 7'h7F;
        endcase
    end

    always_comb begin
        an_c  = ~(8'b1 << dig);
        seg_c = {~pt[dig], hex_c};
        if (DEAD_EN && (cnt < 16'(DEAD_CYC))) begin
            an_c = 8'hFF;
        end
        if (phase && le[dig]) begin
            seg_c = 8'hFF;
        end
    end

    // Registered display outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            AN         <= 8'hFF;
            SEGMENT    <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            AN         <= an_c;
            SEGMENT    <= seg_c;
            frame_done <= frame_end_c;
        end
    end

endmodule
